da_bit_serializer: RTL
======================

DA_BIT_SERIALIZER -- requirements
Module: da_bit_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk3 and rst.
REQ-002 clk3 SHALL be an input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-004 sample_in SHALL be an input, 8 bits: two's-complement input sample.
REQ-005 sample_valid SHALL be an input, 1 bit: sample_in is offered this cycle.
REQ-006 sample_ready SHALL be an output, 1 bit, registered: the block accepts a sample this cycle.
REQ-007 x1_bit..x8_bit SHALL be outputs, 8 bits each, registered: the current bit-slice of taps 0-7, 8-15, ..., 56-63, where xk_bit[j] is tap (k-1)*8+j.
REQ-008 bit_idx SHALL be an output, 3 bits, registered: the sample bit position carried by the current slices.
REQ-009 bit_valid SHALL be an output, 1 bit, registered: the slices and bit_idx are valid this cycle.
REQ-010 sign_bit SHALL be an output, 1 bit, registered: high when bit_idx==7, so downstream subtracts the LUT term.
REQ-011 frame_last SHALL be an output, 1 bit, registered: high on the final slice of a frame.

Function
REQ-012 The block SHALL hold a 64-entry x 8-bit delay line: tap0 newest, tap63 oldest.
REQ-013 The block SHALL have two states, IDLE and SERIAL.
REQ-014 In IDLE, sample_ready SHALL be 1.
REQ-015 Acceptance: when sample_valid=1 and sample_ready=1 at edge N:
- the delay line shifts by one (tap63 discarded, tap0 = sample_in);
- the state goes to SERIAL;
- sample_ready drops to 0 at N+1.
REQ-016 Slice timing: in SERIAL, the block SHALL emit exactly 8 consecutive slices with bit_valid=1.
- The first slice is visible in the cycle after edge N.
- bit_idx is 0,1,...,7.
- xk_bit[j] = tap[(k-1)*8+j][bit_idx], taken from the post-shift delay line.
REQ-017 Frame end:
- frame_last and sign_bit SHALL be 1 only on the bit_idx==7 slice.
- After that slice, the state returns to IDLE and sample_ready=1 in the following cycle.
- Throughput is one sample per 9 cycles.
REQ-018 sample_valid while sample_ready=0 SHALL be ignored: no shift, no state change; the sender holds the sample until accepted.
REQ-019 Outside SERIAL, bit_valid, sign_bit and frame_last SHALL be 0, x1_bit..x8_bit SHALL be 0, and bit_idx SHALL be 0.
REQ-020 The delay line SHALL be modified only on acceptance or reset, never during SERIAL.

Reset
REQ-021 When rst=1 at an edge, the block SHALL:
- clear all 64 taps to 0;
- set state=IDLE and sample_ready=1;
- set bit_valid=0, sign_bit=0, frame_last=0, bit_idx=0, x1_bit..x8_bit=0.
REQ-022 rst SHALL take priority over a simultaneous sample_valid; that sample is not stored.
REQ-023 rst asserted mid-SERIAL SHALL abort the frame immediately; no further slices are emitted for it.

Configuration
REQ-024 The macro DA_MSB_FIRST_EN SHALL select the bit order.
- Defined: bit_idx sequence is 7,6,...,0; sign_bit is high on the first slice (bit_idx==7); frame_last is high on the bit_idx==0 slice.
- Undefined: LSB-first order per REQ-016/017.
- All other timing is identical in both builds.

Verification
REQ-025 Reset, then accept sample_in=0x81 -> 8 slices:
- x1_bit=0x01 at bit_idx 0 and 7, 0x00 at bit_idx 1-6;
- x2..x8_bit=0 throughout;
- sign_bit/frame_last only at bit_idx 7.
REQ-026 Accept 65 samples of values 1..65 -> on the 65th frame, tap0=65 and tap63=2; the value 1 is gone. Check x8_bit[7] against bit b of 2 for each slice.
REQ-027 Drive sample_valid=1 continuously with changing data -> exactly one acceptance per 9 cycles; only values present while sample_ready=1 enter tap0.
REQ-028 Assert rst for 1 cycle at bit_idx=3 of a frame ->
- next cycle: bit_valid=0, sample_ready=1, all taps 0;
- the next accepted 0x7F gives x1_bit[0]=1 for bit_idx 0-6 and 0 at bit_idx 7.
REQ-029 Build with DA_MSB_FIRST_EN, accept 0x80 -> first slice: bit_idx=7, sign_bit=1, x1_bit=0x01; remaining slices x1_bit=0; frame_last on the bit_idx=0 slice.

Source files
------------

// File: rtl/da_bit_serializer.sv
// Distributed-arithmetic bit serializer: 64-tap x DATA_W delay line emitted as one bit-slice per cycle.
// Build option: define DA_MSB_FIRST_EN for MSB-first slice order (default is LSB-first).
module da_bit_serializer #(
  parameter int DATA_W = 8
) (
  input  logic                       clk3,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic [7:0]                 x1_bit,
  output logic [7:0]                 x2_bit,
  output logic [7:0]                 x3_bit,
  output logic [7:0]                 x4_bit,
  output logic [7:0]                 x5_bit,
  output logic [7:0]                 x6_bit,
  output logic [7:0]                 x7_bit,
  output logic [7:0]                 x8_bit,
  output logic [$clog2(DATA_W)-1:0]  bit_idx,
  output logic                       bit_valid,
  output logic                       sign_bit,
  output logic                       frame_last
);

  localparam int TAPS  = 64;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_ORD = IDX_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_SERIAL} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] taps_q   [TAPS];
  logic signed [DATA_W-1:0] shift_p0 [TAPS];
  logic [TAPS-1:0]          slice_p0, slice_p1;
  logic [IDX_W-1:0]         ord_p0, bit_p0, ord_p1, idx_p1;
  logic                     accept_p0;
  logic                     vld_p1, sign_p1, last_p1, ready_p1;

  // Slice ordinal (0 = first emitted) to sample bit position.
  function automatic logic [IDX_W-1:0] ord_to_bit(input logic [IDX_W-1:0] ord);
`ifdef DA_MSB_FIRST_EN
    return LAST_ORD - ord;
`else
    return ord;
`endif
  endfunction

  always_ff @(posedge clk3) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_p0 = ready_p1 && sample_valid;
    case (state_q)
      S_IDLE:   if (accept_p0) state_d = S_SERIAL;
      S_SERIAL: if (ord_p1 == LAST_ORD) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stage p0: post-shift view of the delay line and next slice selection.
  // On acceptance the first slice must come from the shifted line, not the stored one.
  always_comb begin
    shift_p0[0] = sample_in;
    for (int i = 1; i < TAPS; i++) shift_p0[i] = taps_q[i-1];
    ord_p0   = accept_p0 ? '0 : ord_p1 + 1'b1;
    bit_p0   = ord_to_bit(ord_p0);
    slice_p0 = '0;
    for (int i = 0; i < TAPS; i++)
      slice_p0[i] = accept_p0 ? shift_p0[i][bit_p0] : taps_q[i][bit_p0];
  end

  // Stage p1: registered delay line and slice outputs.
  always_ff @(posedge clk3) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
      ready_p1 <= 1'b1;
      vld_p1   <= 1'b0;
      sign_p1  <= 1'b0;
      last_p1  <= 1'b0;
      idx_p1   <= '0;
      ord_p1   <= '0;
      slice_p1 <= '0;
    end else begin
      if (accept_p0)
        for (int i = 0; i < TAPS; i++) taps_q[i] <= shift_p0[i];
      ready_p1 <= (state_d == S_IDLE);
      if (state_d == S_SERIAL) begin
        vld_p1   <= 1'b1;
        sign_p1  <= (bit_p0 == LAST_ORD);
        last_p1  <= (ord_p0 == LAST_ORD);
        idx_p1   <= bit_p0;
        ord_p1   <= ord_p0;
        slice_p1 <= slice_p0;
      end else begin
        vld_p1   <= 1'b0;
        sign_p1  <= 1'b0;
        last_p1  <= 1'b0;
        idx_p1   <= '0;
        ord_p1   <= '0;
        slice_p1 <= '0;
      end
    end
  end

  assign sample_ready = ready_p1;
  assign bit_valid    = vld_p1;
  assign sign_bit     = sign_p1;
  assign frame_last   = last_p1;
  assign bit_idx      = idx_p1;
  assign x1_bit       = slice_p1[7:0];
  assign x2_bit       = slice_p1[15:8];
  assign x3_bit       = slice_p1[23:16];
  assign x4_bit       = slice_p1[31:24];
  assign x5_bit       = slice_p1[39:32];
  assign x6_bit       = slice_p1[47:40];
  assign x7_bit       = slice_p1[55:48];
  assign x8_bit       = slice_p1[63:56];

endmodule
